// File: rtl/ahb_busmatrix_pkg.sv
// Shared AHB-Lite bus matrix definitions: transfer/burst codes, port select codes
// and the burst-length lookup used by the output-stage arbiters.
package ahb_busmatrix_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        PSEL_NONE  = 2'b00,
        PSEL_DCODE = 2'b01,
        PSEL_ICODE = 2'b10,
        PSEL_SYS   = 2'b11
    } psel_t;

    localparam int BEAT_CNT_W = 4;

    // Remaining beats after the NONSEQ; undefined-length bursts are never locked.
    function automatic logic [BEAT_CNT_W-1:0] burst_beats_m1(input logic [2:0] hburst);
        logic [BEAT_CNT_W-1:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahblite_burst_tracker.sv
// Beat counter and burst lock flag for an AHB-Lite output stage; shared by the
// SRAM, ROM and peripheral arbiters.
module ahblite_burst_tracker
    import ahb_busmatrix_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       hready,
    input  logic       hsel,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       owner_valid,
    output logic       lock
);

    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [BEAT_CNT_W-1:0] beat_cnt_nxt;

    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (owner_valid && hsel && hready) begin
            case (htrans)
                HTRANS_NONSEQ: beat_cnt_nxt = burst_beats_m1(hburst);
                HTRANS_SEQ:    beat_cnt_nxt = (beat_cnt == '0) ? '0 : beat_cnt - 1'b1;
                HTRANS_IDLE:   beat_cnt_nxt = '0;
                default:       beat_cnt_nxt = beat_cnt;
            endcase
        end
    end

    // Lock looks at the post-update count so the NONSEQ beat itself already holds the owner.
    assign lock = (beat_cnt_nxt != '0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            beat_cnt <= '0;
        else
            beat_cnt <= beat_cnt_nxt;
    end

endmodule

// File: rtl/ahblite_busmatrix_arbiter_sram.sv
// Registered arbiter for the shared SRAM output stage (DCODE/ICODE/SYSTEM).
// Fixed priority DCODE > SYS > ICODE by default; ARB_SRAM_ROUND_ROBIN_EN selects round-robin.
module ahblite_busmatrix_arbiter_sram
    import ahb_busmatrix_pkg::*;
#(
    parameter int NUM_PORTS = 3
) (
    input  logic                               HCLK,
    input  logic                               HRESETn,
    input  logic                               REQ_DCODE,
    input  logic                               REQ_ICODE,
    input  logic                               REQ_SYS,
    input  logic                               HREADY_OS,
    input  logic                               HSEL_OS,
    input  logic [1:0]                         HTRANS_OS,
    input  logic [2:0]                         HBURST_OS,
    output logic [$clog2(NUM_PORTS+1)-1:0]     PORT_SEL,
    output logic                               PORT_NOSEL
);

    logic  lock;
    logic  arb_ok;
    logic  any_req;
    psel_t winner;

    ahblite_burst_tracker u_burst_tracker (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .hready      (HREADY_OS),
        .hsel        (HSEL_OS),
        .htrans      (HTRANS_OS),
        .hburst      (HBURST_OS),
        .owner_valid (!PORT_NOSEL),
        .lock        (lock)
    );

    assign arb_ok  = HREADY_OS && !lock && (HTRANS_OS != HTRANS_BUSY);
    assign any_req = REQ_DCODE || REQ_ICODE || REQ_SYS;

`ifdef ARB_SRAM_ROUND_ROBIN_EN
    psel_t last_owner;

    always_comb begin
        winner = PSEL_NONE;
        case (last_owner)
            PSEL_DCODE: begin
                if      (REQ_ICODE) winner = PSEL_ICODE;
                else if (REQ_SYS)   winner = PSEL_SYS;
                else if (REQ_DCODE) winner = PSEL_DCODE;
            end
            PSEL_ICODE: begin
                if      (REQ_SYS)   winner = PSEL_SYS;
                else if (REQ_DCODE) winner = PSEL_DCODE;
                else if (REQ_ICODE) winner = PSEL_ICODE;
            end
            default: begin
                if      (REQ_DCODE) winner = PSEL_DCODE;
                else if (REQ_ICODE) winner = PSEL_ICODE;
                else if (REQ_SYS)   winner = PSEL_SYS;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            last_owner <= PSEL_SYS;
        else if (arb_ok && any_req)
            last_owner <= winner;
    end
`else
    always_comb begin
        winner = PSEL_NONE;
        if      (REQ_DCODE) winner = PSEL_DCODE;
        else if (REQ_SYS)   winner = PSEL_SYS;
        else if (REQ_ICODE) winner = PSEL_ICODE;
    end
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PORT_SEL   <= PSEL_NONE;
            PORT_NOSEL <= 1'b1;
        end else if (arb_ok) begin
            if (any_req) begin
                PORT_SEL   <= winner;
                PORT_NOSEL <= 1'b0;
            end else begin
                PORT_NOSEL <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahblite_busmatrix_arbiter_sram.sv
// Directed self-checking bench for the SRAM output-stage arbiter.
module tb_ahblite_busmatrix_arbiter_sram;

    logic       HCLK;
    logic       HRESETn;
    logic       REQ_DCODE;
    logic       REQ_ICODE;
    logic       REQ_SYS;
    logic       HREADY_OS;
    logic       HSEL_OS;
    logic [1:0] HTRANS_OS;
    logic [2:0] HBURST_OS;
    logic [1:0] PORT_SEL;
    logic       PORT_NOSEL;

    int checks = 0;
    int errors = 0;

    ahblite_busmatrix_arbiter_sram #(.NUM_PORTS(3)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .REQ_DCODE  (REQ_DCODE),
        .REQ_ICODE  (REQ_ICODE),
        .REQ_SYS    (REQ_SYS),
        .HREADY_OS  (HREADY_OS),
        .HSEL_OS    (HSEL_OS),
        .HTRANS_OS  (HTRANS_OS),
        .HBURST_OS  (HBURST_OS),
        .PORT_SEL   (PORT_SEL),
        .PORT_NOSEL (PORT_NOSEL)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] exp_sel, input logic exp_nosel);
        checks++;
        assert (PORT_SEL === exp_sel)
        else begin
            errors++;
            $error("FAIL %s PORT_SEL: observed %b expected %b", tag, PORT_SEL, exp_sel);
        end
        checks++;
        assert (PORT_NOSEL === exp_nosel)
        else begin
            errors++;
            $error("FAIL %s PORT_NOSEL: observed %b expected %b", tag, PORT_NOSEL, exp_nosel);
        end
    endtask

    task automatic drive(input logic d, input logic i, input logic s,
                         input logic rdy, input logic [1:0] tr, input logic [2:0] bu);
        REQ_DCODE = d;
        REQ_ICODE = i;
        REQ_SYS   = s;
        HREADY_OS = rdy;
        HTRANS_OS = tr;
        HBURST_OS = bu;
    endtask

    logic [1:0] last_sel;

    initial begin
        HRESETn = 1'b0;
        HSEL_OS = 1'b1;
        drive(0, 0, 0, 1, 2'b00, 3'b000);

        // reset and release with no requests
        tick();
        tick();
        check("reset", 2'b00, 1'b1);
        HRESETn = 1'b1;
        tick();
        check("release_noreq", 2'b00, 1'b1);
        tick();
        check("release_noreq2", 2'b00, 1'b1);

`ifdef ARB_SRAM_ROUND_ROBIN_EN
        drive(1, 1, 1, 1, 2'b10, 3'b000);
        tick();
        check("rr_1", 2'b01, 1'b0);
        tick();
        check("rr_2", 2'b10, 1'b0);
        tick();
        check("rr_3", 2'b11, 1'b0);
        tick();
        check("rr_4", 2'b01, 1'b0);
        last_sel = 2'b01;
`else
        drive(1, 1, 1, 1, 2'b00, 3'b000);
        tick();
        check("prio_all", 2'b01, 1'b0);
        REQ_DCODE = 1'b0;
        tick();
        check("prio_sys", 2'b11, 1'b0);
        REQ_SYS = 1'b0;
        tick();
        check("prio_icode", 2'b10, 1'b0);
        last_sel = 2'b10;
`endif

        // idle release keeps last code
        drive(0, 0, 0, 1, 2'b00, 3'b000);
        tick();
        check("idle_release", last_sel, 1'b1);

        // INCR4 burst lock with a wait state, SYS drops its request mid-burst
        drive(0, 0, 1, 1, 2'b00, 3'b000);
        tick();
        check("sys_grant", 2'b11, 1'b0);
        drive(1, 0, 1, 1, 2'b10, 3'b011);
        tick();
        check("incr4_nonseq", 2'b11, 1'b0);
        drive(1, 0, 0, 1, 2'b11, 3'b011);
        tick();
        check("incr4_seq1", 2'b11, 1'b0);
        drive(1, 0, 0, 0, 2'b11, 3'b011);
        tick();
        check("incr4_wait", 2'b11, 1'b0);
        drive(1, 0, 0, 1, 2'b11, 3'b011);
        tick();
        check("incr4_seq2", 2'b11, 1'b0);
        drive(1, 0, 0, 1, 2'b11, 3'b011);
        tick();
        check("incr4_seq3_switch", 2'b01, 1'b0);

        // BUSY inside undefined-length INCR blocks a switch; SEQ beat allows it
        drive(1, 0, 0, 1, 2'b10, 3'b001);
        tick();
        check("incr_nonseq", 2'b01, 1'b0);
        drive(0, 1, 0, 1, 2'b01, 3'b001);
        tick();
        check("incr_busy1", 2'b01, 1'b0);
        tick();
        check("incr_busy2", 2'b01, 1'b0);
        drive(0, 1, 0, 1, 2'b11, 3'b001);
        tick();
        check("incr_seq_switch", 2'b10, 1'b0);

        // WRAP8 terminated early by IDLE after two beats
        drive(0, 0, 1, 1, 2'b10, 3'b100);
        tick();
        check("wrap8_nonseq", 2'b10, 1'b0);
        drive(0, 0, 1, 1, 2'b11, 3'b100);
        tick();
        check("wrap8_seq1", 2'b10, 1'b0);
        tick();
        check("wrap8_seq2", 2'b10, 1'b0);
        drive(0, 0, 1, 1, 2'b00, 3'b100);
        tick();
        check("wrap8_idle_switch", 2'b11, 1'b0);

        // asynchronous reset in the middle of an INCR16 burst
        drive(1, 0, 1, 1, 2'b10, 3'b111);
        tick();
        check("incr16_nonseq", 2'b11, 1'b0);
        drive(1, 0, 1, 1, 2'b11, 3'b111);
        tick();
        check("incr16_seq1", 2'b11, 1'b0);
        #3;
        HRESETn = 1'b0;
        #1;
        check("reset_midburst", 2'b00, 1'b1);
        drive(1, 0, 0, 1, 2'b00, 3'b000);
        #2;
        HRESETn = 1'b1;
        tick();
        check("regrant_after_reset", 2'b01, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
